// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide share one 2*XLEN register.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        func3;
    logic [4:0]        rd;
    logic              neg;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] prod;

    logic            is_div;
    logic            sgn1;
    logic            sgn2;
    logic            neg1;
    logic            neg2;
    logic            start_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;

    assign is_div    = func3_i[2];
    assign sgn1      = is_div ? ~func3_i[0] : (func3_i[1] ^ func3_i[0]);
    assign sgn2      = is_div ? ~func3_i[0] : (func3_i[1:0] == 2'b01);
    assign neg1      = sgn1 & rs1_i[XLEN-1];
    assign neg2      = sgn2 & rs2_i[XLEN-1];
    assign abs1      = neg1 ? -rs1_i : rs1_i;
    assign abs2      = neg2 ? -rs2_i : rs2_i;
    assign start_neg = (is_div & func3_i[1]) ? neg1 : (neg1 ^ neg2);
    assign div_zero  = (rs2_i == '0);
    assign div_ovf   = ~func3_i[0]
                     & (rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                     & (rs2_i == '1);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]}
                    + (prod[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, prod[XLEN-1:1]};
    assign div_diff = prod[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    assign div_next = div_diff[XLEN]
                    ? {prod[2*XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};

    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] hi_fix;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fin_res;

    // High half of the negated 2*XLEN product: borrow enters only if low half is 0
    assign lo      = prod[XLEN-1:0];
    assign hi      = prod[2*XLEN-1:XLEN];
    assign hi_fix  = neg ? (~hi + XLEN'(lo == '0)) : hi;
    assign q_fix   = neg ? -lo : lo;
    assign r_fix   = neg ? -hi : hi;
    assign fin_res = func3[2]
                   ? (func3[1] ? r_fix : q_fix)
                   : ((func3[1:0] == 2'b00) ? lo : hi_fix);

    assign busy_o  = (state != IDLE);
    assign stall_o = (start_i & (state == IDLE))
                   | (state == CALC) | (state == FIN);

    always_ff @(posedge clk) begin
        done_o <= 1'b0;
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            func3    <= '0;
            rd       <= '0;
            neg      <= 1'b0;
            opnd     <= '0;
            prod     <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        func3 <= func3_i;
                        rd    <= rd_i;
                        count <= '0;
                        if (is_div && (div_zero || div_ovf)) begin
                            neg   <= 1'b0;
                            opnd  <= '0;
                            state <= FIN;
                            prod  <= div_zero
                                   ? {rs1_i, {XLEN{1'b1}}}
                                   : {{XLEN{1'b0}}, rs1_i};
                        end else begin
                            neg   <= start_neg;
                            state <= CALC;
                            opnd  <= is_div ? abs2 : abs1;
                            prod  <= {{XLEN{1'b0}}, is_div ? abs1 : abs2};
                        end
                    end
                end
                CALC: begin
                    prod  <= func3[2] ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(XLEN-1))
                        state <= FIN;
                end
                FIN: begin
                    result_o <= fin_res;
                    rd_o     <= rd;
                    done_o   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit.
// Hand-computed RV32M vectors, latency, flush and reset checks.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        start_i;
    logic [2:0]  func3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int total = 0;
    int fails = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .start_i  (start_i),
        .func3_i  (func3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        func3_i = f3;
        rs1_i   = a;
        rs2_i   = b;
        rd_i    = rd;
        start_i = 1'b1;
    endtask

    task automatic finish_op(input string tag, input logic [31:0] exp,
                             input logic [4:0] rd, input int lat_exp);
        int lat;
        step();
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 60) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_rd"}, 32'(rd_o), 32'(rd));
    endtask

    initial begin
        int seen;
        rst     = 1'b0;
        flush_i = 1'b0;
        start_i = 1'b0;
        func3_i = '0;
        rs1_i   = '0;
        rs2_i   = '0;
        rd_i    = '0;
        step();
        step();
        chk("rst_res", result_o, 32'h0);
        chk("rst_rd", 32'(rd_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        rst = 1'b1;
        step();

        start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        #1;
        chk("start_stall", 32'(stall_o), 32'h1);
        finish_op("mul", 32'hFFFF_FFEB, 5'd5, 33);
        chk("done_stall", 32'(stall_o), 32'h0);
        chk("done_busy", 32'(busy_o), 32'h0);

        start_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6);
        finish_op("mulh", 32'h4000_0000, 5'd6, 33);
        start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        finish_op("mulhu", 32'hFFFF_FFFE, 5'd7, 33);
        start_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8);
        finish_op("mulhsu", 32'hFFFF_FFFF, 5'd8, 33);

        start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9);
        finish_op("div", 32'hFFFF_FFFD, 5'd9, 33);
        start_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10);
        finish_op("rem", 32'hFFFF_FFFF, 5'd10, 33);
        start_op(3'b101, 32'd100, 32'd7, 5'd11);
        finish_op("divu", 32'd14, 5'd11, 33);
        start_op(3'b111, 32'd100, 32'd7, 5'd12);
        finish_op("remu", 32'd2, 5'd12, 33);

        start_op(3'b101, 32'd5, 32'd0, 5'd13);
        finish_op("divu0", 32'hFFFF_FFFF, 5'd13, 1);
        start_op(3'b110, 32'd5, 32'd0, 5'd14);
        finish_op("rem0", 32'd5, 5'd14, 1);
        start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        finish_op("divovf", 32'h8000_0000, 5'd15, 1);
        start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        finish_op("removf", 32'h0, 5'd16, 1);

        start_op(3'b101, 32'd1000, 32'd3, 5'd17);
        step();
        start_i = 1'b0;
        repeat (10) step();
        chk("pre_flush_busy", 32'(busy_o), 32'h1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'h0);
        chk("flush_stall", 32'(stall_o), 32'h0);
        chk("flush_res", result_o, 32'h0);
        chk("flush_rd", 32'(rd_o), 32'd16);
        seen = 0;
        repeat (40) begin
            step();
            if (done_o) seen++;
        end
        chk("flush_nodone", 32'(seen), 32'h0);

        start_op(3'b000, 32'd9, 32'd9, 5'd20);
        step();
        start_i = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        step();
        chk("mrst_res", result_o, 32'h0);
        chk("mrst_rd", 32'(rd_o), 32'h0);
        chk("mrst_busy", 32'(busy_o), 32'h0);
        chk("mrst_done", 32'(done_o), 32'h0);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (done_o) seen++;
        end
        chk("mrst_nodone", 32'(seen), 32'h0);

        start_op(3'b000, 32'd3, 32'd4, 5'd1);
        finish_op("b2b_a", 32'd12, 5'd1, 33);
        start_op(3'b100, 32'd20, 32'hFFFF_FFFC, 5'd2);
        #1;
        chk("b2b_stall", 32'(stall_o), 32'h1);
        finish_op("b2b_b", 32'hFFFF_FFFB, 5'd2, 33);
        step();
        chk("b2b_pulse", 32'(done_o), 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
